// File: rtl/matrix_det_host_if.sv
// ---------------------------------------------------------------------------
// matrix_det_host_if : host <-> determinant-engine handshake and matrix bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface matrix_det_host_if;
  logic         Start;
  logic         Ack;
  logic [255:0] input_arr_flat;
  logic         Det_q_Load;
  logic         Det_q_Done;
  logic [31:0]  Det;

  modport master (
    output Start, Ack, input_arr_flat,
    input  Det_q_Load, Det_q_Done, Det
  );

  modport slave (
    input  Start, Ack, input_arr_flat,
    output Det_q_Load, Det_q_Done, Det
  );
endinterface

`default_nettype wire

// File: rtl/matrix_det_host.sv
// ---------------------------------------------------------------------------
// matrix_det_host : collects an 8x8 matrix of 4-bit entries, hands it to a
//   determinant engine and reports the result. Optional: ZERO_ROW_SKIP_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matrix_det_host #(
  parameter int TIMEOUT_W = 20
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  input  wire logic [3:0]  Entry_Val,
  input  wire logic        Entry_Wr,
  input  wire logic        Go,
  input  wire logic        Clear,
  matrix_det_host_if.master eng,
  output logic [31:0]      Result,
  output logic             Result_Valid,
  output logic             Error,
  output logic             Skipped,
  output logic [5:0]       Entry_Idx,
  output logic             q_Fill,
  output logic             q_Ready,
  output logic             q_Send,
  output logic             q_Wait,
  output logic             q_Report,
  output logic             q_Err
);

  // One-hot encoding so the q_* outputs are direct register bits
  typedef enum logic [5:0] {
    S_FILL   = 6'b000001,
    S_READY  = 6'b000010,
    S_SEND   = 6'b000100,
    S_WAIT   = 6'b001000,
    S_REPORT = 6'b010000,
    S_ERR    = 6'b100000
  } state_t;

  state_t               state_q, state_d;
  logic [255:0]         mat_q, mat_d;
  logic [5:0]           idx_q, idx_d;
  logic                 start_q, start_d;
  logic                 ack_q, ack_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 skip_q, skip_d;
  logic [31:0]          result_q, result_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 zero_row;

`ifdef ZERO_ROW_SKIP_EN
  always_comb begin
    zero_row = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (mat_q[r*32 +: 32] == 32'd0) zero_row = 1'b1;
    end
  end
`else
  assign zero_row = 1'b0;
`endif

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    idx_d    = idx_q;
    start_d  = start_q;
    ack_d    = 1'b0;
    valid_d  = valid_q;
    err_d    = err_q;
    skip_d   = 1'b0;
    result_d = result_q;
    wd_d     = wd_q;
    if (Clear) begin
      state_d = S_FILL;
      idx_d   = 6'd0;
      start_d = 1'b0;
      err_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (Entry_Wr) begin
            mat_d[{idx_q, 2'b00} +: 4] = Entry_Val;
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd63) state_d = S_READY;
          end
        end
        S_READY, S_REPORT: begin
          if (Go) begin
            if (zero_row) begin
              state_d  = S_REPORT;
              result_d = 32'd0;
              valid_d  = 1'b1;
              skip_d   = 1'b1;
            end else begin
              state_d = S_SEND;
              start_d = 1'b1;
              valid_d = 1'b0;
              wd_d    = '0;
            end
          end
        end
        S_SEND, S_WAIT: begin
          wd_d = wd_inc;
          // Watchdog expiry outranks a simultaneous engine response
          if (wd_inc == '1) begin
            state_d = S_ERR;
            start_d = 1'b0;
            err_d   = 1'b1;
          end else if (eng.Det_q_Done) begin
            state_d  = S_REPORT;
            start_d  = 1'b0;
            result_d = eng.Det;
            valid_d  = 1'b1;
            ack_d    = 1'b1;
          end else if (state_q == S_SEND && eng.Det_q_Load) begin
            state_d = S_WAIT;
            start_d = 1'b0;
          end
        end
        S_ERR: ;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= S_FILL;
      mat_q    <= '0;
      idx_q    <= 6'd0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 1'b0;
      result_q <= 32'd0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
      result_q <= result_d;
      wd_q     <= wd_d;
    end
  end

  assign eng.Start          = start_q;
  assign eng.Ack            = ack_q;
  assign eng.input_arr_flat = mat_q;
  assign Result             = result_q;
  assign Result_Valid       = valid_q;
  assign Error              = err_q;
  assign Skipped            = skip_q;
  assign Entry_Idx          = idx_q;
  assign {q_Err, q_Report, q_Wait, q_Send, q_Ready, q_Fill} = state_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_det_host.sv
// ---------------------------------------------------------------------------
// tb_matrix_det_host : directed and randomized bench with a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matrix_det_host;
  localparam int TW       = 8;
  localparam int TO_LIMIT = (1 << TW) - 1;
`ifdef ZERO_ROW_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam int ST_FILL = 0, ST_READY = 1, ST_SEND = 2, ST_WAIT = 3, ST_REPORT = 4, ST_ERR = 5;

  logic        Clk = 1'b0;
  logic        Reset, Entry_Wr, Go, Clear;
  logic [3:0]  Entry_Val;
  logic [31:0] Result;
  logic        Result_Valid, Error, Skipped;
  logic [5:0]  Entry_Idx;
  logic        q_Fill, q_Ready, q_Send, q_Wait, q_Report, q_Err;

  matrix_det_host_if bus();

  matrix_det_host #(.TIMEOUT_W(TW)) dut (
    .Clk(Clk), .Reset(Reset), .Entry_Val(Entry_Val), .Entry_Wr(Entry_Wr),
    .Go(Go), .Clear(Clear), .eng(bus), .Result(Result),
    .Result_Valid(Result_Valid), .Error(Error), .Skipped(Skipped),
    .Entry_Idx(Entry_Idx), .q_Fill(q_Fill), .q_Ready(q_Ready), .q_Send(q_Send),
    .q_Wait(q_Wait), .q_Report(q_Report), .q_Err(q_Err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 1'b0;
  int          m_st, m_idx, m_busy;
  logic [3:0]  m_mat [64];
  bit          m_start, m_ack, m_valid, m_err, m_skip;
  logic [31:0] m_result;

  function automatic bit has_zero_row();
    bit z;
    for (int r = 0; r < 8; r++) begin
      z = 1'b1;
      for (int c = 0; c < 8; c++) if (m_mat[r*8+c] != 4'd0) z = 1'b0;
      if (z) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 64; k++) f[k*4 +: 4] = m_mat[k];
    return f;
  endfunction

  task automatic model_step();
    m_ack  = 1'b0;
    m_skip = 1'b0;
    if (!Reset) begin
      m_known = 1'b1; m_st = ST_FILL; m_idx = 0; m_busy = 0;
      for (int k = 0; k < 64; k++) m_mat[k] = 4'd0;
      m_start = 1'b0; m_result = 32'd0; m_valid = 1'b0; m_err = 1'b0;
    end else if (!m_known) begin
      m_known = 1'b0;
    end else if (Clear) begin
      m_st = ST_FILL; m_idx = 0; m_start = 1'b0; m_err = 1'b0; m_valid = 1'b0;
    end else if (m_st == ST_FILL) begin
      if (Entry_Wr) begin
        m_mat[m_idx] = Entry_Val;
        m_idx = (m_idx + 1) % 64;
        if (m_idx == 0) m_st = ST_READY;
      end
    end else if (m_st == ST_READY || m_st == ST_REPORT) begin
      if (Go && SKIP_EN && has_zero_row()) begin
        m_st = ST_REPORT; m_result = 32'd0; m_valid = 1'b1; m_skip = 1'b1;
      end else if (Go) begin
        m_st = ST_SEND; m_start = 1'b1; m_valid = 1'b0; m_busy = 0;
      end
    end else if (m_st == ST_SEND || m_st == ST_WAIT) begin
      m_busy++;
      if (m_busy >= TO_LIMIT) begin
        m_st = ST_ERR; m_start = 1'b0; m_err = 1'b1;
      end else if (bus.Det_q_Done) begin
        m_st = ST_REPORT; m_start = 1'b0; m_result = bus.Det; m_valid = 1'b1; m_ack = 1'b1;
      end else if (m_st == ST_SEND && bus.Det_q_Load) begin
        m_st = ST_WAIT; m_start = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Single compare process: every cycle once the model is initialised
  initial forever begin
    @(negedge Clk);
    if (m_known) begin
      check("outs",
            {Result, Result_Valid, Error, Skipped, bus.Start, bus.Ack, Entry_Idx,
             q_Err, q_Report, q_Wait, q_Send, q_Ready, q_Fill},
            {m_result, m_valid, m_err, m_skip, m_start, m_ack, 6'(m_idx), 6'(1 << m_st)});
      check("flat", bus.input_arr_flat, model_flat());
    end
  end

  // ---------------- engine responder ----------------
  // mode 0: Load then Done, 1: Done without Load, 2: never answers
  int          eng_mode = 0, eng_load_dly = 1, eng_done_dly = 3, eng_phase = 0, eng_cnt = 0;
  logic [31:0] eng_det = 32'd1;
  bit          eng_rand = 1'b0;

  initial begin
    bus.Det_q_Load = 1'b0;
    bus.Det_q_Done = 1'b0;
    bus.Det        = 32'd0;
    forever begin
      @(negedge Clk);
      bus.Det_q_Load = 1'b0;
      bus.Det_q_Done = 1'b0;
      bus.Det        = $urandom;
      if (eng_phase == 0 && bus.Start) begin
        if (eng_rand) begin
          eng_mode     = ($urandom_range(0, 19) < 2) ? 2 : (($urandom_range(0, 5) == 0) ? 1 : 0);
          eng_load_dly = $urandom_range(0, 4);
          eng_done_dly = $urandom_range(0, 6);
          eng_det      = $urandom;
        end
        eng_cnt   = eng_load_dly;
        eng_phase = (eng_mode == 2) ? 3 : 1;
      end
      if (eng_phase == 1) begin
        if (!bus.Start) eng_phase = 0;
        else if (eng_cnt == 0) begin
          if (eng_mode == 1) begin
            bus.Det_q_Done = 1'b1; bus.Det = eng_det; eng_phase = 0;
          end else begin
            bus.Det_q_Load = 1'b1; eng_cnt = eng_done_dly; eng_phase = 2;
          end
        end else eng_cnt--;
      end else if (eng_phase == 2) begin
        if (eng_cnt == 0) begin
          bus.Det_q_Done = 1'b1; bus.Det = eng_det; eng_phase = 0;
        end else eng_cnt--;
      end else if (eng_phase == 3 && !bus.Start) begin
        eng_phase = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit clr, input bit go, input bit wr, input logic [3:0] val);
    Clear = clr; Go = go; Entry_Wr = wr; Entry_Val = val;
    @(negedge Clk);
    Clear = 1'b0; Go = 1'b0; Entry_Wr = 1'b0; Entry_Val = 4'd0;
  endtask

  // kind 0: identity, 1: all ones except an all-zero row 3
  task automatic fill(input int kind, input int first, input int last);
    for (int k = first; k <= last; k++)
      apply(1'b0, 1'b0, 1'b1, (kind == 0) ? ((k % 9 == 0) ? 4'd1 : 4'd0)
                                          : ((k / 8 == 3) ? 4'd0 : 4'd1));
  endtask

  task automatic run_to_report(output int acks, output bit saw_wait, output bit start_in_wait,
                               output bit ok);
    acks = 0; saw_wait = 1'b0; start_in_wait = 1'b0; ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (bus.Ack) acks++;
      if (q_Wait) begin
        saw_wait = 1'b1;
        if (bus.Start) start_in_wait = 1'b1;
      end
      if (q_Report) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  int           acks, n;
  bit           saw_wait, siw, ok;
  logic [255:0] flat_a;

  initial begin
    Reset = 1'b0; Clear = 1'b0; Go = 1'b0; Entry_Wr = 1'b0; Entry_Val = 4'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check("rst_fill", q_Fill, 1'b1);
    check("rst_idx", Entry_Idx, 6'd0);
    check("rst_flat", bus.input_arr_flat, 256'd0);
    check("rst_start", bus.Start, 1'b0);
    check("rst_ack", bus.Ack, 1'b0);
    check("rst_result", Result, 32'd0);

    // Identity matrix, determinant 1
    fill(0, 0, 63);
    check("id_ready", q_Ready, 1'b1);
    check("id_e0", bus.input_arr_flat[3:0], 4'd1);
    check("id_e9", bus.input_arr_flat[39:36], 4'd1);
    check("id_e63", bus.input_arr_flat[255:252], 4'd1);
    check("id_e1", bus.input_arr_flat[7:4], 4'd0);
    eng_mode = 0; eng_load_dly = 1; eng_done_dly = 3; eng_det = 32'd1;
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    check("id_start", bus.Start, 1'b1);
    run_to_report(acks, saw_wait, siw, ok);
    check("id_report", ok, 1'b1);
    check("id_wait_seen", saw_wait, 1'b1);
    check("id_start_dropped", siw, 1'b0);
    check("id_result", Result, 32'd1);
    check("id_valid", Result_Valid, 1'b1);
    @(negedge Clk);
    check("id_acks", acks, 1);
    check("id_ack_low", bus.Ack, 1'b0);

    // Result -42, then recompute the retained matrix
    eng_det = 32'hFFFF_FFD6;
    flat_a  = bus.input_arr_flat;
    for (int rep = 0; rep < 2; rep++) begin
      apply(1'b0, 1'b1, 1'b0, 4'd0);
      check("m42_valid_clr", Result_Valid, 1'b0);
      run_to_report(acks, saw_wait, siw, ok);
      check("m42_report", ok, 1'b1);
      check("m42_result", Result, 32'hFFFF_FFD6);
      check("m42_flat", bus.input_arr_flat, flat_a);
      @(negedge Clk);
      check("m42_acks", acks, 1);
    end

    // Done before Load completes the request
    eng_mode = 1; eng_load_dly = 2; eng_det = 32'd77;
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    run_to_report(acks, saw_wait, siw, ok);
    check("early_report", ok, 1'b1);
    check("early_nowait", saw_wait, 1'b0);
    check("early_result", Result, 32'd77);

    // Entry_Wr together with Clear at index 30
    apply(1'b1, 1'b0, 1'b0, 4'd0);
    fill(0, 0, 29);
    check("wc_idx30", Entry_Idx, 6'd30);
    apply(1'b1, 1'b0, 1'b1, 4'd7);
    check("wc_idx", Entry_Idx, 6'd0);
    check("wc_fill", q_Fill, 1'b1);
    check("wc_e30", bus.input_arr_flat[123:120], 4'd0);
    check("wc_valid", Result_Valid, 1'b0);

    // Watchdog
    fill(0, 0, 63);
    eng_mode = 2;
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    n = 0;
    while (!q_Err && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("wd_cycles", n, 255);
    check("wd_error", Error, 1'b1);
    check("wd_start", bus.Start, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    check("wd_hold", Error, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 4'd0);
    check("wd_clr_err", Error, 1'b0);
    check("wd_clr_fill", q_Fill, 1'b1);

    // Reset while the engine is being driven
    fill(0, 0, 63);
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    check("rs_start", bus.Start, 1'b0);
    check("rs_ack", bus.Ack, 1'b0);
    check("rs_fill", q_Fill, 1'b1);
    check("rs_flat", bus.input_arr_flat, 256'd0);

    // Row 3 all zero
    fill(1, 0, 63);
    eng_mode = 0; eng_load_dly = 0; eng_done_dly = 1; eng_det = 32'd9;
    apply(1'b0, 1'b1, 1'b0, 4'd0);
`ifdef ZERO_ROW_SKIP_EN
    check("zr_skip", Skipped, 1'b1);
    check("zr_start", bus.Start, 1'b0);
    check("zr_result", Result, 32'd0);
    check("zr_valid", Result_Valid, 1'b1);
    check("zr_report", q_Report, 1'b1);
    @(negedge Clk);
    check("zr_skip_pulse", Skipped, 1'b0);
    check("zr_start_low", bus.Start, 1'b0);
`else
    check("zr_start", bus.Start, 1'b1);
    check("zr_noskip", Skipped, 1'b0);
    run_to_report(acks, saw_wait, siw, ok);
    check("zr_report", ok, 1'b1);
    check("zr_result", Result, 32'd9);
`endif

    // Randomized traffic
    eng_rand = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      Reset     = ($urandom_range(0, 799) != 0);
      Clear     = ($urandom_range(0, 199) == 0);
      Go        = ($urandom_range(0, 5) == 0);
      Entry_Wr  = $urandom_range(0, 1);
      Entry_Val = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      @(negedge Clk);
    end
    Reset = 1'b1; Clear = 1'b0; Go = 1'b0; Entry_Wr = 1'b0; Entry_Val = 4'd0;
    repeat (4) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_det_host.md
MATRIX_DET_HOST -- requirements
Module: matrix_det_host

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 20, width of the SEND+WAIT watchdog counter.
REQ-002 SHALL have port Clk  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-low reset; Reset=0 at a rising Clk edge resets the block.
REQ-004 SHALL have ports Entry_Val  in  4  matrix entry value; Entry_Wr  in  1  one-cycle entry write strobe.
REQ-005 SHALL have ports Go  in  1  request determinant; Clear  in  1  restart entry.
REQ-006 SHALL have ports Det_q_Load  in  1, Det_q_Done  in  1, Det  in  32  status and result from the determinant engine.
REQ-007 SHALL have ports Start  out  1, Ack  out  1, input_arr_flat  out  256  handshake and matrix to the engine.
REQ-008 SHALL have ports Result  out  32, Result_Valid  out  1, Error  out  1, Skipped  out  1, Entry_Idx  out  6.
REQ-009 SHALL have one-hot state outputs q_Fill, q_Ready, q_Send, q_Wait, q_Report, q_Err, each out 1.

Function
REQ-010 SHALL hold an 8x8 matrix of 4-bit unsigned entries, row-major; entry k (row k/8, column k%8) drives input_arr_flat[k*4+:4].
REQ-011 SHALL implement states FILL, READY, SEND, WAIT, REPORT, ERR; every output registered.
REQ-012 FILL: Entry_Wr=1 writes Entry_Val to entry Entry_Idx and increments Entry_Idx; the write at index 63 wraps Entry_Idx to 0 and moves to READY.
REQ-013 READY or REPORT: Go=1 moves to SEND with Start=1 next cycle, clears Result_Valid and the watchdog.
REQ-014 SEND: Start held 1 until Det_q_Load=1 is sampled; then Start=0 and state WAIT.
REQ-015 WAIT: Det_q_Done=1 captures Det into Result, sets Result_Valid=1, pulses Ack=1 for exactly one cycle, moves to REPORT.
REQ-016 REPORT: Result and Result_Valid held; matrix retained, so a new Go recomputes the same matrix.
REQ-017 Watchdog counts every cycle in SEND and WAIT; at all-ones it forces Start=0, Error=1 and state ERR; Error held until Clear.
REQ-018 Clear=1 in any state: state FILL, Entry_Idx=0, Start=0, Error=0, Result_Valid=0; matrix contents retained until overwritten.
REQ-019 Priority: Clear over Go over Entry_Wr; strobes in a state that does not use them are ignored.
REQ-020 Entry_Wr and Clear in the same cycle: entry not written, Entry_Idx=0.
REQ-021 Det_q_Done seen in SEND (before q_Load) is treated as WAIT completion.

Reset
REQ-022 On Reset=0: state FILL, Entry_Idx=0, all matrix entries 0 (input_arr_flat=0), Start=0, Ack=0, Result=0, Result_Valid=0, Error=0, Skipped=0, watchdog 0.
REQ-023 Reset in SEND or WAIT SHALL drop Start and Ack the next cycle without issuing Ack.

Configuration
REQ-024 With macro ZERO_ROW_SKIP_EN defined: on Go, if any row has all eight entries 0, state goes directly to REPORT with Result=0, Result_Valid=1, Skipped pulsed one cycle, Start never asserted.
REQ-025 Without ZERO_ROW_SKIP_EN: no row check, Skipped tied 0, every Go goes to SEND.

Verification
REQ-026 Reset=0 one cycle -> q_Fill=1, Entry_Idx=0, input_arr_flat=0, Start=0, Ack=0, Result=0.
REQ-027 Write 64 entries of identity (1 on diagonal), Go; model raises Det_q_Load 2 cycles later, Det_q_Done with Det=1 later -> input_arr_flat[0+:4]=1, [36+:4]=1, [252+:4]=1, Start drops after q_Load, Result=1, Result_Valid=1, one-cycle Ack.
REQ-028 At Entry_Idx=30 assert Entry_Wr and Clear together -> Entry_Idx=0, entry 30 unchanged, q_Fill=1.
REQ-029 TIMEOUT_W=8, model never asserts Det_q_Done -> Error=1 and q_Err=1 after 255 cycles in SEND+WAIT, Start=0; Clear -> Error=0, q_Fill=1.
REQ-030 ZERO_ROW_SKIP_EN defined, row 3 all zero, Go -> Result=0, Skipped pulse, Start stays 0; macro undefined, same stimulus -> Start=1.
REQ-031 From REPORT with Result=-42, Go again -> identical input_arr_flat, second Result=-42, second single Ack pulse.
